mult_acc: RTL and testbench
===========================

# mult_acc

Sequential accumulator that sits directly downstream of the 4x4 array multiplier `mult`. It captures the 8-bit products over a valid/ready handshake and sums a fixed-length batch of them into a wider accumulator. It presents the batch total with a sticky overflow flag on an output valid/ready handshake. It turns the purely combinational multiplier into a multiply-accumulate (dot-product) path.

## Interface
- `PW`, 8: product width; matches `mult` output `p[7:0]`.
- `AW`, 12: accumulator and result width; must satisfy `AW >= PW`.
- `N`, 4: products per batch; must satisfy `N >= 1`.
- `CW`, `$clog2(N+1)`: batch counter width (derived).

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `clr` in 1: synchronous batch abort/clear.
- `in_p` in PW: product from `mult.p`.
- `in_valid` in 1: `in_p` is valid this cycle.
- `in_ready` out 1: block accepts `in_p` this cycle.
- `out_sum` out AW: batch total, modulo 2^AW.
- `out_ovf` out 1: at least one carry out of bit AW-1 occurred during the batch.
- `out_valid` out 1: `out_sum`/`out_ovf` are valid.
- `out_ready` in 1: consumer takes the result.

## Operation
- There are two states, `ACC` and `DONE`. After reset the block is in `ACC` with the accumulator = 0, count = 0 and ovf = 0.
- `in_ready` = (state == `ACC`). It is decoded combinationally from the state register only and does not depend on `in_valid`.
- A product is accepted when `in_valid & in_ready & ~clr`. On accept:
  - the accumulator becomes `acc + zero-extend(in_p)`, truncated to AW;
  - ovf is set if the add carries out of bit AW-1 (sticky);
  - count increments.
- On the accept that brings count to N:
  - the state moves to `DONE` and count returns to 0;
  - `out_sum` is loaded with the final accumulator value including this product, and `out_ovf` with the final ovf.
- In `DONE`:
  - `out_valid` = 1;
  - `out_sum` and `out_ovf` are held stable until `out_valid & out_ready`;
  - `in_ready` = 0, so no products are accepted.
- On `out_valid & out_ready` in `DONE`, the next state is `ACC`, with the accumulator = 0, ovf = 0 and `out_valid` = 0.
- `clr` (when `rst` = 0) has priority over every transfer. On a `clr` cycle:
  - the next state is `ACC`, with the accumulator, count, ovf and `out_valid` all cleared;
  - a product presented in the same cycle is discarded;
  - a result pending in `DONE` is dropped, even if `out_ready` = 1.
- `rst` has priority over `clr`. Reset in the middle of a batch discards the partial sum.
- Reset values: `out_sum` = 0, `out_ovf` = 0, `out_valid` = 0, `in_ready` = 1.
- Width rule: the adder is AW+1 bits wide, and bit AW is the carry that feeds ovf. Products are unsigned.

## Timing
- Accept at edge k means the accumulator is updated at edge k. The sum becomes visible internally in cycle k+1.
- Result latency: the Nth accept at edge k makes `out_valid` = 1 starting in cycle k+1.
- Throughput:
  - With `out_ready` held at 1, a batch occupies N `ACC` cycles plus 1 `DONE` cycle, so there is 1 bubble per batch.
  - With `out_ready` = 0, the block stalls indefinitely in `DONE`.
- All outputs are registered except `in_ready`, which is state-decoded only. There is no combinational path from `in_valid`/`out_ready` to any output.

## Structure
- Shared package `mult_pkg` holds:
  - the state encoding constants `ST_ACC` = 1'b0 and `ST_DONE` = 1'b1;
  - the default widths `PW` = 8 and `AW` = 12.
- Sub-module `acc_add`: an AW-bit ripple-carry adder built from the existing `fa` cell, with a carry-out port used for ovf. The `mult_acc` top holds the FSM, counter and registers.

## Test plan
- Reset, then N = 4 products 3, 5, 7, 9 with `out_ready` = 1. Expected: `out_valid` one cycle after the 4th accept, `out_sum` = 24, `out_ovf` = 0, and `in_ready` back to 1 the following cycle.
- Products 225 ×4 (15×15) back-to-back. Expected: `out_sum` = 900. With AW = 9: `out_sum` = 900 − 512 = 388 and `out_ovf` = 1.
- Backpressure with `out_ready` = 0 for 5 cycles after the result is ready. Expected: `out_sum`/`out_valid` stable, `in_ready` = 0, extra `in_valid` ignored. Raising `out_ready` completes the transfer, and the next batch starts from 0.
- `in_valid` toggling 1,0,1,0 with values 10, 20, 30, 40. Expected: only the valid cycles count, and `out_sum` = 100.
- `clr` asserted after 2 accepts (sum 50), concurrent with `in_valid` carrying 70. Expected: 70 discarded; the next 4 products of 1 give `out_sum` = 4.
- `rst` asserted while in `DONE` with `out_ready` = 1. Expected: next cycle `out_valid` = 0, `out_sum` = 0 and `in_ready` = 1, with no result transferred.

Source files
------------

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and state encoding for the multiplier/accumulator path
package mult_pkg;

  localparam int PW = 8;
  localparam int AW = 12;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_DONE = 1'b1
  } state_e;

endpackage

// File: rtl/acc_add.sv
// rtl/acc_add.sv - W-bit ripple-carry adder with carry-out, built from fa cells
module acc_add #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  assign cout = c[W];

endmodule

// File: rtl/fa.sv
// rtl/fa.sv - one-bit full adder cell
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mult_acc.sv
// rtl/mult_acc.sv - batch accumulator of N unsigned products with sticky overflow and output handshake
module mult_acc #(
  parameter int PW = mult_pkg::PW,
  parameter int AW = mult_pkg::AW,
  parameter int N  = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [PW-1:0] in_p,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [AW-1:0] out_sum,
  output logic          out_ovf,
  output logic          out_valid,
  input  logic          out_ready
);

  import mult_pkg::*;

  localparam int CW = $clog2(N + 1);

  state_e        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic          out_ovf_q, out_ovf_d;
  logic          out_valid_q, out_valid_d;

  logic [AW-1:0] add_sum;
  logic          add_cout;
  logic          accept;

  acc_add #(.W(AW)) u_add (
    .a    (acc_q),
    .b    (AW'(in_p)),
    .sum  (add_sum),
    .cout (add_cout)
  );

  assign in_ready = (state_q == ST_ACC);
  assign accept   = in_valid & in_ready & ~clr;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    // clr outranks both the input accept and a pending output transfer
    if (clr) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      acc_d = add_sum;
      ovf_d = ovf_q | add_cout;
      if (cnt_q == CW'(N - 1)) begin
        state_d     = ST_DONE;
        cnt_d       = '0;
        out_sum_d   = add_sum;
        out_ovf_d   = ovf_q | add_cout;
        out_valid_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_d     = ST_ACC;
      acc_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_acc.sv
// tb/tb_mult_acc.sv - self-checking bench for mult_acc at AW=12 and AW=9
module tb_mult_acc;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [7:0]  in_p;
  logic        in_ready, out_valid, out_ovf;
  logic [11:0] out_sum;
  logic        in_ready9, out_valid9, out_ovf9;
  logic [8:0]  out_sum9;

  always #5 clk = ~clk;

  mult_acc #(.PW(8), .AW(12), .N(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_p(in_p), .in_valid(in_valid),
    .in_ready(in_ready), .out_sum(out_sum), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mult_acc #(.PW(8), .AW(9), .N(N)) dut9 (
    .clk(clk), .rst(rst), .clr(clr), .in_p(in_p), .in_valid(in_valid),
    .in_ready(in_ready9), .out_sum(out_sum9), .out_ovf(out_ovf9),
    .out_valid(out_valid9), .out_ready(out_ready)
  );

  int errors = 0;
  int checks = 0;

  // reference: running integer batch total, exact result kept unreduced
  int m_sum, m_cnt, m_total;
  bit m_pend;

  typedef struct {
    logic        v;
    logic [7:0]  p;
    logic        o;
    logic        ev;
    logic        er;
    logic [11:0] es;
    logic        eo;
    logic [8:0]  es9;
    logic        eo9;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic c, input logic v,
                       input logic [7:0] p, input logic o);
    rst = r; clr = c; in_valid = v; in_p = p; out_ready = o;
    @(posedge clk);
    if (r) begin
      m_pend = 0; m_sum = 0; m_cnt = 0; m_total = 0;
    end else if (c) begin
      m_pend = 0; m_sum = 0; m_cnt = 0;
    end else if (!m_pend) begin
      if (v) begin
        m_sum += int'(p);
        m_cnt++;
        if (m_cnt == N) begin
          m_pend = 1; m_total = m_sum; m_sum = 0; m_cnt = 0;
        end
      end
    end else if (o) begin
      m_pend = 0;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_pend));
    chk({tag, " in_ready"}, 32'(in_ready), 32'(!m_pend));
    chk({tag, " out_valid9"}, 32'(out_valid9), 32'(m_pend));
    chk({tag, " in_ready9"}, 32'(in_ready9), 32'(!m_pend));
    if (m_pend) begin
      chk({tag, " out_sum"}, 32'(out_sum), m_total % 4096);
      chk({tag, " out_ovf"}, 32'(out_ovf), 32'(m_total >= 4096));
      chk({tag, " out_sum9"}, 32'(out_sum9), m_total % 512);
      chk({tag, " out_ovf9"}, 32'(out_ovf9), 32'(m_total >= 512));
    end
  endtask

  task automatic batch(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic o);
    cycle(0, 0, 1, a, o); check_model("batch");
    cycle(0, 0, 1, b, o); check_model("batch");
    cycle(0, 0, 1, c, o); check_model("batch");
    cycle(0, 0, 1, d, o); check_model("batch");
  endtask

  initial begin
    tbl[0] = '{1'b1, 8'd3,   1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[1] = '{1'b1, 8'd5,   1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[2] = '{1'b1, 8'd7,   1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[3] = '{1'b1, 8'd9,   1'b1, 1'b1, 1'b0, 12'd24,  1'b0, 9'd24,  1'b0};
    tbl[4] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[5] = '{1'b1, 8'd225, 1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[6] = '{1'b1, 8'd225, 1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[7] = '{1'b1, 8'd225, 1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};
    tbl[8] = '{1'b1, 8'd225, 1'b1, 1'b1, 1'b0, 12'd900, 1'b0, 9'd388, 1'b1};
    tbl[9] = '{1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 12'd0,   1'b0, 9'd0,   1'b0};

    cycle(1, 0, 0, 8'd0, 0);
    cycle(1, 0, 0, 8'd0, 0);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset in_ready", 32'(in_ready), 1);
    chk("reset out_sum", 32'(out_sum), 0);
    chk("reset out_ovf", 32'(out_ovf), 0);
    chk("reset out_sum9", 32'(out_sum9), 0);

    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, tbl[i].v, tbl[i].p, tbl[i].o);
      chk($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].er));
      if (tbl[i].ev) begin
        chk($sformatf("tbl[%0d] out_sum", i), 32'(out_sum), 32'(tbl[i].es));
        chk($sformatf("tbl[%0d] out_ovf", i), 32'(out_ovf), 32'(tbl[i].eo));
        chk($sformatf("tbl[%0d] out_sum9", i), 32'(out_sum9), 32'(tbl[i].es9));
        chk($sformatf("tbl[%0d] out_ovf9", i), 32'(out_ovf9), 32'(tbl[i].eo9));
      end
    end

    // backpressure: result held while stalled, extra inputs ignored
    batch(8'd50, 8'd50, 8'd50, 8'd50, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 8'd99, 0);
      check_model("stall");
      chk("stall out_sum", 32'(out_sum), 200);
      chk("stall in_ready", 32'(in_ready), 0);
    end
    cycle(0, 0, 1, 8'd99, 1);
    check_model("release");
    chk("release out_valid", 32'(out_valid), 0);
    batch(8'd1, 8'd2, 8'd3, 8'd4, 0);
    chk("after stall out_sum", 32'(out_sum), 10);
    cycle(0, 0, 0, 8'd0, 1);
    check_model("drain");

    // gaps in in_valid do not count
    cycle(0, 0, 1, 8'd10, 1); check_model("gap");
    cycle(0, 0, 0, 8'd99, 1); check_model("gap");
    cycle(0, 0, 1, 8'd20, 1); check_model("gap");
    cycle(0, 0, 0, 8'd99, 1); check_model("gap");
    cycle(0, 0, 1, 8'd30, 1); check_model("gap");
    cycle(0, 0, 0, 8'd99, 1); check_model("gap");
    cycle(0, 0, 1, 8'd40, 1); check_model("gap");
    chk("gap out_sum", 32'(out_sum), 100);
    chk("gap out_valid", 32'(out_valid), 1);
    cycle(0, 0, 0, 8'd0, 1); check_model("gap drain");

    // clr mid-batch discards partial sum and the concurrent product
    cycle(0, 0, 1, 8'd25, 1); check_model("clr");
    cycle(0, 0, 1, 8'd25, 1); check_model("clr");
    cycle(0, 1, 1, 8'd70, 1); check_model("clr");
    batch(8'd1, 8'd1, 8'd1, 8'd1, 1);
    chk("clr out_sum", 32'(out_sum), 4);
    chk("clr out_valid", 32'(out_valid), 1);

    // clr drops a pending result even with out_ready high
    cycle(0, 1, 0, 8'd0, 1); check_model("clr done");
    chk("clr done out_valid", 32'(out_valid), 0);

    // rst while a result is pending
    batch(8'd5, 8'd5, 8'd5, 8'd5, 0);
    cycle(1, 0, 0, 8'd0, 1);
    chk("rst done out_valid", 32'(out_valid), 0);
    chk("rst done out_sum", 32'(out_sum), 0);
    chk("rst done out_ovf", 32'(out_ovf), 0);
    chk("rst done in_ready", 32'(in_ready), 1);
    chk("rst done out_sum9", 32'(out_sum9), 0);
    check_model("rst done");

    for (int i = 0; i < 400; i++) begin
      logic r, c, v, o;
      logic [7:0] p;
      r = ($urandom_range(0, 63) == 0);
      c = ($urandom_range(0, 31) == 0);
      v = ($urandom_range(0, 3) != 0);
      o = ($urandom_range(0, 2) != 0);
      p = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
      cycle(r, c, v, p, o);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
